// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: drives a req/ack data bus, stalls the pipeline while busy, and registers MEM/WB outputs.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word accesses skip the bus and raise bus_err instead of truncating.
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif
`ifndef NOPRegAddr
`define NOPRegAddr 5'b00000
`endif
`ifndef WriteDisable
`define WriteDisable 1'b0
`endif

module mem_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [`RegBus]     mem_wdata,
  input  logic [`RegAddrBus] mem_wd,
  input  logic               mem_wreg,
  input  logic [3:0]         mem_op,
  input  logic [`RegBus]     mem_sdata,
  output logic               bus_req,
  output logic               bus_we,
  output logic [`RegBus]     bus_addr,
  output logic [3:0]         bus_sel,
  output logic [`RegBus]     bus_wdata,
  input  logic [`RegBus]     bus_rdata,
  input  logic               bus_ack,
  output logic               stallreq,
  output logic               bus_err,
  output logic [`RegBus]     wb_wdata,
  output logic [`RegAddrBus] wb_wd,
  output logic               wb_wreg
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [1:0]         off_q, off_d;
  logic [`RegBus]     cap_q, cap_d;
  logic               cap_ok_q, cap_ok_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [`RegBus]     bus_addr_q, bus_addr_d;
  logic [3:0]         bus_sel_q, bus_sel_d;
  logic [`RegBus]     bus_wdata_q, bus_wdata_d;
  logic               bus_err_q, bus_err_d;
  logic [`RegBus]     wb_wdata_q, wb_wdata_d;
  logic [`RegAddrBus] wb_wd_q, wb_wd_d;
  logic               wb_wreg_q, wb_wreg_d;

  logic           in_load, in_store, in_mem, q_load, issue_ok;
  logic [3:0]     sel_new;
  logic [`RegBus] wdata_new;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;
  logic [`RegBus] ld_val;

  assign in_load  = (mem_op >= 4'd1) && (mem_op <= 4'd5);
  assign in_store = (mem_op >= 4'd6) && (mem_op <= 4'd8);
  assign in_mem   = in_load || in_store;
  assign q_load   = (op_q >= 4'd1) && (op_q <= 4'd5);

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (mem_op)
      4'd3, 4'd4, 4'd7: misaligned = mem_wdata[0];
      4'd5, 4'd8:       misaligned = (mem_wdata[1:0] != 2'b00);
      default:          misaligned = 1'b0;
    endcase
  end
  assign issue_ok = !misaligned;
`else
  assign issue_ok = 1'b1;
`endif

  // Big-endian lanes: offset 0 is bits 31:24, so sel[3] is the lowest address.
  always_comb begin
    sel_new   = 4'b1111;
    wdata_new = '0;
    case (mem_op)
      4'd1, 4'd2, 4'd6: sel_new = 4'b1000 >> mem_wdata[1:0];
      4'd3, 4'd4, 4'd7: sel_new = mem_wdata[1] ? 4'b0011 : 4'b1100;
      default:          sel_new = 4'b1111;
    endcase
    case (mem_op)
      4'd6:    wdata_new = {4{mem_sdata[7:0]}};
      4'd7:    wdata_new = {2{mem_sdata[15:0]}};
      4'd8:    wdata_new = mem_sdata;
      default: wdata_new = '0;
    endcase
  end

  always_comb begin
    rd_byte = bus_rdata[31:24];
    case (off_q)
      2'd0:    rd_byte = bus_rdata[31:24];
      2'd1:    rd_byte = bus_rdata[23:16];
      2'd2:    rd_byte = bus_rdata[15:8];
      default: rd_byte = bus_rdata[7:0];
    endcase
    rd_half = off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    case (op_q)
      4'd1:    ld_val = {{24{rd_byte[7]}}, rd_byte};
      4'd2:    ld_val = {24'd0, rd_byte};
      4'd3:    ld_val = {{16{rd_half[15]}}, rd_half};
      4'd4:    ld_val = {16'd0, rd_half};
      default: ld_val = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    cap_d       = cap_q;
    cap_ok_d    = cap_ok_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    bus_err_d   = 1'b0;
    wb_wdata_d  = wb_wdata_q;
    wb_wd_d     = wb_wd_q;
    wb_wreg_d   = wb_wreg_q;
    stallreq    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_mem) begin
          stallreq   = 1'b1;
          op_d       = mem_op;
          off_d      = mem_wdata[1:0];
          cnt_d      = '0;
          wb_wdata_d = `ZeroWord;
          wb_wd_d    = `NOPRegAddr;
          wb_wreg_d  = `WriteDisable;
          if (issue_ok) begin
            bus_req_d   = 1'b1;
            bus_we_d    = in_store;
            bus_addr_d  = {mem_wdata[31:2], 2'b00};
            bus_sel_d   = sel_new;
            bus_wdata_d = wdata_new;
            cap_ok_d    = 1'b1;
            state_d     = S_WAIT;
          end else begin
            bus_err_d = 1'b1;
            cap_d     = '0;
            cap_ok_d  = 1'b0;
            state_d   = S_DONE;
          end
        end else begin
          wb_wdata_d = mem_wdata;
          wb_wd_d    = mem_wd;
          wb_wreg_d  = mem_wreg;
        end
      end
      S_WAIT: begin
        stallreq = 1'b1;
        // Ack is tested before the limit so a same-cycle ack completes normally.
        if (bus_ack) begin
          if (q_load) cap_d = ld_val;
          cap_ok_d  = 1'b1;
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          cap_d     = '0;
          cap_ok_d  = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        wb_wdata_d = q_load ? cap_q : mem_wdata;
        wb_wd_d    = mem_wd;
        wb_wreg_d  = q_load ? (mem_wreg && cap_ok_q) : 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      off_q       <= '0;
      cap_q       <= '0;
      cap_ok_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      wb_wdata_q  <= `ZeroWord;
      wb_wd_q     <= `NOPRegAddr;
      wb_wreg_q   <= `WriteDisable;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      cap_q       <= cap_d;
      cap_ok_q    <= cap_ok_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      bus_err_q   <= bus_err_d;
      wb_wdata_q  <= wb_wdata_d;
      wb_wd_q     <= wb_wd_d;
      wb_wreg_q   <= wb_wreg_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err   = bus_err_q;
  assign wb_wdata  = wb_wdata_q;
  assign wb_wd     = wb_wd_q;
  assign wb_wreg   = wb_wreg_q;

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Performs data-bus transactions for load/store instructions over a req/ack bus and stalls the pipeline while a transaction is outstanding.
- Registers the MEM/WB stage outputs (wb_*) consumed by the register-file write port.

Parameters:
- TIMEOUT, 16, max cycles in WAIT before abort; legal 2..255; counter width 8 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- mem_wdata  in  `RegBus  ALU result (address for ld/st)
- mem_wd  in  `RegAddrBus  destination register
- mem_wreg  in  1  write enable from EX/MEM
- mem_op  in  4  0=none 1=LB 2=LBU 3=LH 4=LHU 5=LW 6=SB 7=SH 8=SW; 9..15 treated as none
- mem_sdata  in  `RegBus  store data (rt value)
- bus_req  out  1  transaction request
- bus_we  out  1  1=write
- bus_addr  out  `RegBus  word address, bits[1:0]=00
- bus_sel  out  4  byte lanes; sel[3]=bits 31:24
- bus_wdata  out  `RegBus  lane-replicated store data
- bus_rdata  in  `RegBus  read data, valid with ack
- bus_ack  in  1  completion strobe
- stallreq  out  1  hold upstream stages
- bus_err  out  1  one-cycle pulse on timeout
- wb_wdata  out  `RegBus  write-back data
- wb_wd  out  `RegAddrBus  write-back register
- wb_wreg  out  1  write-back enable

Behaviour:
- Byte order is big-endian: offset 0 maps to bits 31:24.
- Reset, synchronous and active-high:
  - state=IDLE, counter=0.
  - bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0, bus_err=0.
  - wb_wdata=`ZeroWord, wb_wd=`NOPRegAddr, wb_wreg=`WriteDisable.
  - Reset mid-transaction abandons it with no write-back. Any late bus_ack is ignored in IDLE.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - mem_op none: no bus activity, stallreq=0. Each edge: wb_wdata<=mem_wdata, wb_wd<=mem_wd, wb_wreg<=mem_wreg. Latency is 1 cycle, same as a plain pipeline register.
  - mem_op is load/store: stallreq=1 combinationally. At the edge, register bus_addr={mem_wdata[31:2],2'b00}, bus_we (1 for ops 6..8), bus_sel and bus_wdata. Set bus_req=1, counter=0, go to WAIT. wb_* is loaded with a bubble (wb_wreg=0).
- bus_sel by op and offset:
  - byte: one-hot lane for offset.
  - half: offset[1]=0 gives 1100, offset[1]=1 gives 0011.
  - word: 1111.
- bus_wdata: SB replicates the byte x4, SH replicates the half x2, SW passes data through.
- Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) truncate the address to the aligned lane; no error (see optional feature).
- WAIT:
  - stallreq=1; bus_req and all bus outputs held stable.
  - bus_ack=1: capture the extracted load value, deassert bus_req, go to DONE.
    - LB/LH sign-extend the selected lane; LBU/LHU zero-extend; LW passes through.
    - Stores capture nothing.
  - No ack: counter++. When counter reaches TIMEOUT-1 without ack, abort: bus_req=0, bus_err pulses 1 cycle, captured result=0, write enable forced 0, go to DONE.
  - Ack on the same cycle as the timeout limit: ack wins.
- DONE:
  - stallreq=0; upstream inputs are still stable.
  - At the edge: wb_wdata<=captured value for loads, mem_wdata for stores. wb_wd<=mem_wd. wb_wreg<=mem_wreg for loads (0 after timeout) and 0 for stores.
  - Return to IDLE.
- Total latency for a memory op with ack in the cycle after request entry: 3 edges (IDLE→WAIT→DONE→IDLE with wb valid).
- Back-to-back memory ops: the IDLE following DONE starts the next op immediately; no bus_req dead cycle beyond that.
- bus_ack while not in WAIT is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: misaligned half/word access detected in IDLE issues no bus request. bus_err pulses one cycle on the following cycle, FSM goes directly to DONE, and wb_wreg=0 for that instruction.
- Not defined: misalignment is ignored and the address is truncated as above.

Test Plan:
- Reset: assert rst with mem_op=5 mid-WAIT → next cycle bus_req=0, wb_wreg=0, wb_wd=0, stallreq=0; a later bus_ack produces no write-back.
- Non-memory op: mem_wdata=0x12345678, mem_wd=3, mem_wreg=1, mem_op=0 → after 1 edge wb_wdata=0x12345678, wb_wd=3, wb_wreg=1, bus_req never 1.
- LB sign extension: mem_op=1, mem_wdata=0x00001001, ack with bus_rdata=0x11F02233 after 2 WAIT cycles → bus_sel=0100, stallreq high until DONE, wb_wdata=0xFFFFFFF0, wb_wreg=1.
- SH lane: mem_op=7, mem_wdata=0x00000202, mem_sdata=0xAAAABEEF → bus_we=1, bus_sel=0011, bus_wdata=0xBEEFBEEF, bus_addr=0x00000200, wb_wreg=0.
- Timeout: TIMEOUT=4, mem_op=5, no ack → bus_err pulses once, bus_req drops, wb_wreg=0, stallreq released.
- Ack/timeout collision plus back-to-back: ack exactly at the limit cycle with bus_rdata=0xCAFEBABE → wb_wdata=0xCAFEBABE, no bus_err; a following SW starts bus_req in the cycle after DONE.
